spi_master: RTL and testbench

Parametrised SPI master: the next-generation replacement for the fixed 16-bit, receive-only, single-slave SPI port on the MIPS system (`sdo_i`/`sck_o`/`cs_o`). It adds:
- configurable frame length and SCK divider;
- all four CPOL/CPHA modes and MSB/LSB-first ordering;
- full-duplex transmit on `sdi_o`;
- up to `NUM_CS` one-hot active-low chip selects.

It sits between the memory-mapped peripheral bus glue and the board pins, with a start/busy/done handshake toward the CPU side.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clkgen.sv | 26 ++
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and SPI mode constants for the SPI master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period down-counter emitting a one-cycle tick every div clk cycles
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    assign reload = (div == '0) ? '0 : div - 1'b1;
    assign tick   = (cnt == '0);

    // Held at reload while load is high; restarts a full half-period after each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= (load || tick) ? reload : cnt - 1'b1;
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: full-duplex SPI master with configurable length, divider, mode, bit order and chip select
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 1,
    parameter int DIV_W  = 8,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [DATA_W-1:0]           tx_data_i,
    input  logic [$clog2(DATA_W+1)-1:0] len_i,
    input  logic [DIV_W-1:0]            div_i,
    input  logic                        cpol_i,
    input  logic                        cpha_i,
    input  logic                        lsb_first_i,
    input  logic [CS_W-1:0]             cs_sel_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [DATA_W-1:0]           rx_data_o,
    output logic                        sck_o,
    output logic [NUM_CS-1:0]           cs_o,
    output logic                        sdi_o,
    input  logic                        sdo_i
);

    localparam int LW = $clog2(DATA_W + 1);
    localparam logic [LW-1:0] DW = LW'(DATA_W);

    state_t            state;
    logic              tick, cpha, lsb, sample, drive, last;
    logic [LW-1:0]     n, n_eff;
    logic [LW:0]       half;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, tx_al;
    logic [NUM_CS-1:0] cs_dec;

    function automatic logic out_bit(input logic l, input logic [DATA_W-1:0] v);
        return l ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic l, input logic [DATA_W-1:0] v);
        return l ? v >> 1 : v << 1;
    endfunction

    // Out-of-range selects match no line, leaving every chip select high
    for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
        assign cs_dec[i] = (cs_sel_i != CS_W'(i));
    end

    assign n_eff  = (len_i == '0 || len_i > DW) ? DW : len_i;
    // MSB-first words are pre-aligned so bit N-1 sits at the top of the shifter
    assign tx_al  = lsb_first_i ? tx_data_i : tx_data_i << (DW - n_eff);
    assign last   = (half == {n, 1'b0} - 1'b1);
    assign sample = cpha ? half[0] : ~half[0];
    assign drive  = cpha ? ~half[0] : (half[0] & ~last);

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .load (state == IDLE),
        .div  (state == IDLE ? div_i : div_q),
        .tick (tick)
    );

    // Transfer sequencer: latches config on start, walks SETUP/SHIFT/HOLD/GAP and drives all pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
            sck_o     <= 1'b0;
            cs_o      <= '1;
            sdi_o     <= 1'b0;
            cpha      <= 1'b0;
            lsb       <= 1'b0;
            n         <= '0;
            div_q     <= '0;
            half      <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    state  <= SETUP;
                    busy_o <= 1'b1;
                    cs_o   <= cs_dec;
                    sck_o  <= cpol_i;
                    cpha   <= cpha_i;
                    lsb    <= lsb_first_i;
                    n      <= n_eff;
                    div_q  <= div_i;
                    half   <= '0;
                    rx_sr  <= '0;
                    // CPHA=0 presents the first bit before any SCK edge
                    sdi_o  <= cpha_i ? 1'b0 : out_bit(lsb_first_i, tx_al);
                    tx_sr  <= cpha_i ? tx_al : shift_word(lsb_first_i, tx_al);
                end
                SETUP: if (tick) state <= SHIFT;
                SHIFT: if (tick) begin
                    sck_o <= ~sck_o;
                    half  <= half + 1'b1;
                    if (sample)
                        rx_sr <= lsb ? {sdo_i, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], sdo_i};
                    if (drive) begin
                        sdi_o <= out_bit(lsb, tx_sr);
                        tx_sr <= shift_word(lsb, tx_sr);
                    end
                    if (last) begin
                        state <= HOLD;
                        sdi_o <= 1'b0;
                    end
                end
                HOLD: if (tick) begin
                    state <= GAP;
                    cs_o  <= '1;
                end
                GAP: if (tick) begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b1;
                    // LSB-first bits arrive at the top of the shifter and are brought down here
                    rx_data_o <= lsb ? rx_sr >> (DW - n) : rx_sr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed scoreboard bench with a behavioural SPI slave
module tb_spi_master;
    import spi_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, start_i = 1'b0;
    logic [15:0] tx_data_i = '0;
    logic [4:0]  len_i = '0;
    logic [7:0]  div_i = '0;
    logic        cpol_i = 1'b0, cpha_i = 1'b0, lsb_first_i = 1'b0;
    logic [1:0]  cs_sel_i = '0;
    logic        busy_o, done_o, sck_o, sdi_o;
    logic [15:0] rx_data_o;
    logic [3:0]  cs_o;
    logic        sdo_i = 1'b0;

    int compared = 0, mismatched = 0;
    logic [15:0] exp_rx_q[$], exp_tx_q[$];

    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    int          s_n = 16;
    logic [15:0] s_word = '0, m_got = '0;
    logic        act = 1'b0, sck_prev = 1'b0, prev_sdi = 1'b0;
    int          sk = 0, lead_cnt = 0, edges = 0;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .tx_data_i(tx_data_i), .len_i(len_i),
        .div_i(div_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
        .cs_sel_i(cs_sel_i), .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o),
        .sck_o(sck_o), .cs_o(cs_o), .sdi_o(sdi_o), .sdo_i(sdo_i)
    );

    function automatic logic [3:0] bpos(input int k);
        return 4'(s_lsb ? k : s_n - 1 - k);
    endfunction

    // Slave: shifts s_word out on MISO and collects MOSI into m_got, per its own mode
    always @(negedge clk) begin
        if (busy_o && !act) begin
            act = 1'b1; sk = 0; lead_cnt = 0; m_got = '0; sck_prev = sck_o;
            sdo_i = s_cpha ? 1'b0 : s_word[bpos(0)];
        end else if (!busy_o) act = 1'b0;
        if (sck_o !== sck_prev) begin
            edges++;
            if (act && sck_o != s_cpol) begin
                lead_cnt++;
                if (s_cpha) begin sdo_i = s_word[bpos(sk)]; sk++; end
                else m_got[bpos(lead_cnt - 1)] = prev_sdi;
            end else if (act) begin
                if (s_cpha) m_got[bpos(lead_cnt - 1)] = prev_sdi;
                else begin sk++; if (sk < s_n) sdo_i = s_word[bpos(sk)]; end
            end
        end
        sck_prev = sck_o;
        prev_sdi = sdi_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [15:0] tx, input logic [4:0] len, input logic [7:0] div,
                         input logic [1:0] mode, input logic lsb, input logic [1:0] sel,
                         input logic [15:0] sw, input int n, input int cyc, input logic [3:0] ecs,
                         input logic poke, input logic hold);
        int cnt = 0;
        tx_data_i = tx; len_i = len; div_i = div; {cpol_i, cpha_i} = mode;
        lsb_first_i = lsb; cs_sel_i = sel; start_i = 1'b1;
        s_word = sw; s_n = n; {s_cpol, s_cpha} = mode; s_lsb = lsb;
        exp_rx_q.push_back(sw);
        exp_tx_q.push_back(tx & 16'((32'h1 << n) - 1));
        @(posedge clk); #1;
        start_i = hold;
        check("busy_start", busy_o, 1);
        check("cs_start", cs_o, ecs);
        check("sck_idle_start", sck_o, mode[1]);
        while (!done_o && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
            if (poke && cnt == 5) begin cs_sel_i = 2'd0; tx_data_i = ~tx; len_i = 5'd4; div_i = 8'd7; end
            if (poke && cnt == 10) check("cs_mid", cs_o, ecs);
            if (poke && cnt == 20) start_i = 1'b1;
            if (poke && cnt == 21) start_i = 1'b0;
        end
        check("done_cycle", cnt, cyc);
        check("busy_done", busy_o, 0);
        check("leading_edges", lead_cnt, n);
        check("rx_data", rx_data_o, exp_rx_q.pop_front());
        check("mosi", m_got, exp_tx_q.pop_front());
        check("sck_idle_end", sck_o, mode[1]);
    endtask

    initial begin
        int nd, nb, t, e0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rx", rx_data_o, 0);
        check("rst_sck", sck_o, 0);
        check("rst_cs", cs_o, 4'hF);
        check("rst_sdi", sdi_o, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        frame(16'hA5C3, 5'd16, 8'd2, SPI_MODE0, 1'b0, 2'd0, 16'h1EE0, 16, 70, 4'b1110, 1'b0, 1'b0);
        frame(16'h00F0, 5'd12, 8'd1, SPI_MODE3, 1'b1, 2'd1, 16'h0ABC, 12, 27, 4'b1101, 1'b0, 1'b0);
        check("rx_upper_zero", rx_data_o[15:12], 0);
        frame(16'h1234, 5'd0, 8'd0, SPI_MODE1, 1'b0, 2'd2, 16'hBEEF, 16, 35, 4'b1011, 1'b1, 1'b0);
        nd = 0; nb = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            nd += int'(done_o);
            nb += int'(busy_o);
        end
        check("ignored_start_done", nd, 0);
        check("ignored_start_busy", nb, 0);
        frame(16'h0015, 5'd5, 8'd3, SPI_MODE2, 1'b0, 2'd3, 16'h000A, 5, 39, 4'b0111, 1'b0, 1'b0);
        frame(16'hC0DE, 5'd20, 8'd1, SPI_MODE0, 1'b1, 2'd0, 16'h4321, 16, 35, 4'b1110, 1'b0, 1'b1);
        frame(16'h5A5A, 5'd16, 8'd1, SPI_MODE1, 1'b0, 2'd1, 16'h9669, 16, 35, 4'b1101, 1'b0, 1'b0);

        tx_data_i = 16'hFFFF; len_i = 5'd16; div_i = 8'd2; {cpol_i, cpha_i} = SPI_MODE0;
        lsb_first_i = 1'b0; cs_sel_i = 2'd0; start_i = 1'b1;
        s_word = 16'hFFFF; s_n = 16; {s_cpol, s_cpha} = SPI_MODE0; s_lsb = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        e0 = edges; t = 0;
        while (edges < e0 + 5 && t < 500) begin @(posedge clk); #1; t++; end
        check("reset_edge_wait", t < 500, 1);
        rst = 1'b0;
        #1;
        check("midrst_cs", cs_o, 4'hF);
        check("midrst_sck", sck_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_sdi", sdi_o, 0);
        @(negedge clk) rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            nd += int'(done_o) + int'(busy_o);
        end
        check("post_rst_quiet", nd, 0);
        frame(16'h003C, 5'd8, 8'd1, SPI_MODE0, 1'b0, 2'd0, 16'h00A6, 8, 19, 4'b1110, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
